hazard_ctrl: RTL and testbench

- Pipeline interlock and forwarding controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Sits beside the ID stage and consumes the decoded register fields and control bits.
- Tracks in-flight destination registers in EX/MEM/WB and issues stall, bubble and flush controls plus registered forwarding selects to the EX operand muxes.
- Sequences load-use stalls and branch/JAL redirect flushes with a small FSM.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Interlock, redirect-flush sequencing and registered EX forwarding selects
// for a 5-stage RV32I pipeline. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwrite,
  input  logic              i_id_memtoreg,
  input  logic              i_ex_redirect,
  output logic              o_stall,
  output logic              o_bubble_ex,
  output logic              o_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t            state;
  logic [2:0]        flush_left;

  logic              ex_valid, ex_regwrite, ex_load;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid, mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_regwrite;
  logic [REG_AW-1:0] wb_rd;

  logic ex_hit_a, mem_hit_a, wb_hit_a;
  logic ex_hit_b, mem_hit_b, wb_hit_b;
  logic load_use, issue;

  function automatic logic slot_match(input logic valid, input logic regwrite,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs,
                                      input logic use_rs);
    return valid & regwrite & (rd != '0) & (rd == rs) & use_rs;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic wb_hit);
    if (ex_hit)       return 2'b01;
    else if (mem_hit) return 2'b10;
    else if (wb_hit)  return 2'b11;
    else              return 2'b00;
  endfunction

  assign ex_hit_a  = slot_match(ex_valid,  ex_regwrite,  ex_rd,  i_id_rs1, i_id_use_rs1);
  assign mem_hit_a = slot_match(mem_valid, mem_regwrite, mem_rd, i_id_rs1, i_id_use_rs1);
  assign wb_hit_a  = slot_match(wb_valid,  wb_regwrite,  wb_rd,  i_id_rs1, i_id_use_rs1);
  assign ex_hit_b  = slot_match(ex_valid,  ex_regwrite,  ex_rd,  i_id_rs2, i_id_use_rs2);
  assign mem_hit_b = slot_match(mem_valid, mem_regwrite, mem_rd, i_id_rs2, i_id_use_rs2);
  assign wb_hit_b  = slot_match(wb_valid,  wb_regwrite,  wb_rd,  i_id_rs2, i_id_use_rs2);

  assign load_use    = i_id_valid & ex_load & (ex_hit_a | ex_hit_b);
  assign o_flush     = i_ex_redirect | (state == FLUSH);
  assign o_stall     = load_use & ~o_flush;
  assign o_bubble_ex = o_stall | o_flush;
  assign issue       = i_id_valid & ~o_stall & ~o_flush;

  // Tracking slots; the load flag only matters while the producer sits in EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_load      <= 1'b0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
      o_fwd_a      <= 2'b00;
      o_fwd_b      <= 2'b00;
    end else begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      ex_valid     <= issue;
      ex_regwrite  <= issue & i_id_regwrite;
      ex_load      <= issue & i_id_memtoreg;
      ex_rd        <= i_id_rd;
      o_fwd_a      <= issue ? fwd_sel(ex_hit_a, mem_hit_a, wb_hit_a) : 2'b00;
      o_fwd_b      <= issue ? fwd_sel(ex_hit_b, mem_hit_b, wb_hit_b) : 2'b00;
    end
  end

  // Redirect beats a load-use stall; a redirect during FLUSH does not reload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RUN;
      flush_left <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (i_ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              state      <= FLUSH;
              flush_left <= 3'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            state <= LDSTALL;
          end
        end
        LDSTALL: state <= RUN;
        FLUSH: begin
          if (flush_left <= 3'd1) begin
            state      <= RUN;
            flush_left <= 3'd0;
          end else begin
            flush_left <= flush_left - 3'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (o_stall) stall_cnt <= stall_cnt + 32'd1;
      if (o_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a distance-based pipeline model.
module tb_hazard_ctrl;
  localparam int FC = 2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        id_regwrite = 1'b0, id_memtoreg = 1'b0, ex_redirect = 1'b0;
  logic        stall, bubble_ex, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_rd(id_rd), .i_id_regwrite(id_regwrite), .i_id_memtoreg(id_memtoreg),
    .i_ex_redirect(ex_redirect),
    .o_stall(stall), .o_bubble_ex(bubble_ex), .o_flush(flush),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: hist[d] is the instruction issued into EX d cycles ago.
  typedef struct packed {logic valid; logic regwrite; logic load; logic [4:0] rd;} ent_t;
  ent_t        hist [1:3];
  int          flush_rem;
  bit          ldstall;
  bit          adv_en;
  logic        m_hazard, m_flush, m_stall, m_bubble;
  logic [1:0]  m_fwd_a, m_fwd_b;
  logic [31:0] m_scnt, m_fcnt;

  function automatic bit writes(input ent_t e, input logic [4:0] rs, input logic use_rs);
    return e.valid && e.regwrite && (e.rd != 0) && (e.rd == rs) && use_rs;
  endfunction

  function automatic int nearest(input logic [4:0] rs, input logic use_rs);
    for (int d = 1; d <= 3; d++)
      if (writes(hist[d], rs, use_rs)) return d;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 1; d <= 3; d++) hist[d] = '0;
    flush_rem = 0; ldstall = 0;
    m_fwd_a = 2'b00; m_fwd_b = 2'b00;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_eval();
    m_hazard = id_valid && hist[1].load &&
               (writes(hist[1], id_rs1, id_use_rs1) || writes(hist[1], id_rs2, id_use_rs2));
    m_flush  = ex_redirect || (flush_rem > 0);
    m_stall  = m_hazard && !m_flush;
    m_bubble = m_stall || m_flush;
  endtask

  task automatic model_advance();
    bit issued;
    issued  = id_valid && !m_bubble;
    m_fwd_a = issued ? 2'(nearest(id_rs1, id_use_rs1)) : 2'b00;
    m_fwd_b = issued ? 2'(nearest(id_rs2, id_use_rs2)) : 2'b00;
    if (PERF) begin
      if (m_stall) m_scnt = m_scnt + 1;
      if (m_flush) m_fcnt = m_fcnt + 1;
    end
    if (flush_rem > 0)     flush_rem--;
    else if (ldstall)      ldstall = 0;
    else if (ex_redirect)  flush_rem = FC - 1;
    else if (m_hazard)     ldstall = 1;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = issued ? ent_t'{1'b1, id_regwrite, id_memtoreg, id_rd} : ent_t'('0);
  endtask

  task automatic apply(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit redir);
    if (adv_en) model_advance();
    @(negedge clk);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = rw; id_memtoreg = ld; ex_redirect = redir;
    #1;
    model_eval();
    adv_en = 1;
  endtask

  task automatic idle();            apply(0, 0, 0, 0, 0, 0, 0, 0, 0);       endtask
  task automatic alu(input int rd, input int rs1, input int rs2);
    apply(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
  endtask
  task automatic load(input int rd, input int rs1); apply(1, rs1, 0, 1, 0, rd, 1, 1, 0); endtask

  task automatic set_idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_memtoreg = 0; ex_redirect = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle_inputs();
    rst_n = 0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if (bubble_ex !== 1'b0) $display("FAIL rst_bubble: got %b want 0", bubble_ex); else n_pass++;
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL rst_fwd_a: got %b want 00", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL rst_fwd_b: got %b want 00", fwd_b); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL rst_scnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd0) $display("FAIL rst_fcnt: got %0d want 0", flush_cnt); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    model_eval();
    adv_en = 1;
  endtask

  task automatic test_back_to_back();
    repeat (3) idle();
    alu(5, 1, 2);
    alu(6, 5, 7);
    n_checks++; if (stall !== 1'b0) $display("FAIL b2b_stall: got %b want 0", stall); else n_pass++;
    idle();
    n_checks++; if (fwd_a !== 2'b01) $display("FAIL b2b_fwd_a: got %b want 01", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL b2b_fwd_b: got %b want 00", fwd_b); else n_pass++;
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    repeat (3) idle();
    load(5, 1);
    alu(6, 5, 5);
    s0 = stall_cnt;
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
    n_checks++; if (bubble_ex !== 1'b1) $display("FAIL lu_bubble: got %b want 1", bubble_ex); else n_pass++;
    alu(6, 5, 5);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", stall); else n_pass++;
    idle();
    n_checks++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a: got %b want 10", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b10) $display("FAIL lu_fwd_b: got %b want 10", fwd_b); else n_pass++;
    n_checks++;
    if (stall_cnt !== s0 + (PERF ? 32'd1 : 32'd0))
      $display("FAIL lu_scnt: got %0d want %0d", stall_cnt, s0 + (PERF ? 32'd1 : 32'd0));
    else n_pass++;
  endtask

  task automatic test_x0();
    repeat (3) idle();
    alu(0, 1, 2);
    alu(1, 0, 0);
    n_checks++; if (stall !== 1'b0) $display("FAIL x0_stall: got %b want 0", stall); else n_pass++;
    idle();
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL x0_fwd_a: got %b want 00", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL x0_fwd_b: got %b want 00", fwd_b); else n_pass++;
    load(0, 1);
    alu(2, 0, 0);
    n_checks++; if (stall !== 1'b0) $display("FAIL x0_load_stall: got %b want 0", stall); else n_pass++;
  endtask

  task automatic test_redirect();
    repeat (3) idle();
    apply(1, 1, 2, 1, 1, 3, 1, 0, 1);
    n_checks++; if (flush !== 1'b1) $display("FAIL rd_flush0: got %b want 1", flush); else n_pass++;
    n_checks++; if (bubble_ex !== 1'b1) $display("FAIL rd_bubble0: got %b want 1", bubble_ex); else n_pass++;
    alu(4, 1, 2);
    n_checks++; if (flush !== 1'b1) $display("FAIL rd_flush1: got %b want 1", flush); else n_pass++;
    alu(7, 3, 4);
    n_checks++; if (flush !== 1'b0) $display("FAIL rd_flush2: got %b want 0", flush); else n_pass++;
    idle();
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL rd_killed_a: got %b want 00", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b00) $display("FAIL rd_killed_b: got %b want 00", fwd_b); else n_pass++;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (flush !== 1'b1) $display("FAIL rd_reflush: got %b want 1", flush); else n_pass++;
    idle();
    n_checks++; if (flush !== 1'b0) $display("FAIL rd_noreload: got %b want 0", flush); else n_pass++;
    load(5, 1);
    apply(1, 5, 5, 1, 1, 6, 1, 0, 1);
    n_checks++; if (stall !== 1'b0) $display("FAIL rd_vs_lu_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (flush !== 1'b1) $display("FAIL rd_vs_lu_flush: got %b want 1", flush); else n_pass++;
  endtask

  task automatic test_distance();
    repeat (3) idle();
    alu(9, 1, 2);
    alu(11, 1, 2);
    alu(12, 1, 2);
    alu(13, 9, 9);
    idle();
    n_checks++; if (fwd_a !== 2'b11) $display("FAIL d3_fwd_a: got %b want 11", fwd_a); else n_pass++;
    n_checks++; if (fwd_b !== 2'b11) $display("FAIL d3_fwd_b: got %b want 11", fwd_b); else n_pass++;
    repeat (3) idle();
    alu(9, 1, 2);
    alu(11, 1, 2);
    alu(12, 1, 2);
    alu(14, 1, 2);
    alu(13, 9, 9);
    idle();
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL d4_fwd_a: got %b want 00", fwd_a); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(7) != 0, $urandom_range(7), $urandom_range(7),
            $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0);
      n_checks++; if (stall !== m_stall) $display("FAIL rnd_stall c%0d: got %b want %b", i, stall, m_stall); else n_pass++;
      n_checks++; if (flush !== m_flush) $display("FAIL rnd_flush c%0d: got %b want %b", i, flush, m_flush); else n_pass++;
      n_checks++; if (bubble_ex !== m_bubble) $display("FAIL rnd_bubble c%0d: got %b want %b", i, bubble_ex, m_bubble); else n_pass++;
      n_checks++; if (fwd_a !== m_fwd_a) $display("FAIL rnd_fwd_a c%0d: got %b want %b", i, fwd_a, m_fwd_a); else n_pass++;
      n_checks++; if (fwd_b !== m_fwd_b) $display("FAIL rnd_fwd_b c%0d: got %b want %b", i, fwd_b, m_fwd_b); else n_pass++;
      n_checks++; if (stall_cnt !== m_scnt) $display("FAIL rnd_scnt c%0d: got %0d want %0d", i, stall_cnt, m_scnt); else n_pass++;
      n_checks++; if (flush_cnt !== m_fcnt) $display("FAIL rnd_fcnt c%0d: got %0d want %0d", i, flush_cnt, m_fcnt); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) idle();
    load(5, 1);
    alu(6, 5, 5);
    n_checks++; if (stall !== 1'b1) $display("FAIL mid_pre_stall: got %b want 1", stall); else n_pass++;
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (bubble_ex !== 1'b0) $display("FAIL mid_bubble: got %b want 0", bubble_ex); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL mid_flush: got %b want 0", flush); else n_pass++;
    n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL mid_fwd: got %b want 0000", {fwd_a, fwd_b}); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL mid_scnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (flush_cnt !== 32'd0) $display("FAIL mid_fcnt: got %0d want 0", flush_cnt); else n_pass++;
    @(negedge clk);
    set_idle_inputs();
    rst_n = 1;
    model_reset();
    model_eval();
    adv_en = 1;
    alu(6, 5, 5);
    n_checks++; if (stall !== 1'b0) $display("FAIL mid_post_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL mid_post_flush: got %b want 0", flush); else n_pass++;
    idle();
    n_checks++; if (fwd_a !== 2'b00) $display("FAIL mid_post_fwd: got %b want 00", fwd_a); else n_pass++;
  endtask

  initial begin
    adv_en = 0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_redirect();
    test_distance();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
